mem_dma_engine: RTL and testbench



---
 rtl/mem_dma_if.sv | 36 +++
 rtl/mem_dma_engine.sv | 165 ++++++++++++++++
 tb/tb_mem_dma_engine.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_if.sv
// Control and RAM-port bundle between the DMA engine and its surroundings.
interface mem_dma_if #(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned DATA_W = 32
);
  // Request side
  logic              start;
  logic              mode;
  logic [31:0]       src_addr;
  logic [31:0]       dst_addr;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] fill_data;
  logic              abort;
  // Status side
  logic              busy;
  logic              done;
  logic              aborted;
  logic [LEN_W-1:0]  words_done;
  // RAM port
  logic [31:0]       mem_a;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  // Engine side: owns status and the RAM address/write lines
  modport master (
    input  start, mode, src_addr, dst_addr, len, fill_data, abort, mem_rd,
    output busy, done, aborted, words_done, mem_a, mem_we, mem_wd
  );

  // Requester/RAM side
  modport slave (
    output start, mode, src_addr, dst_addr, len, fill_data, abort, mem_rd,
    input  busy, done, aborted, words_done, mem_a, mem_we, mem_wd
  );
endinterface

// File: rtl/mem_dma_engine.sv
// Word-granular copy/fill initiator on the single-port data RAM.
module mem_dma_engine #(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_dma_if.master bus
);

  localparam int unsigned ADDR_W = 32;
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FILL,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_src_ptr;
  logic [ADDR_W-1:0]   r_dst_ptr;
  logic [LEN_W-1:0]    r_rem;
  logic [LEN_W-1:0]    r_words_done;
  logic [DATA_W-1:0]   r_fill;
  logic [DATA_W-1:0]   r_rd_buf;
  logic                r_mode;
  logic                r_busy;
  logic                r_done;
  logic                r_aborted;

  logic [ADDR_W-1:0]   w_mem_a;
  logic                w_mem_we;
  logic [DATA_W-1:0]   w_mem_wd;
  logic                w_last;

  assign w_last = (r_rem == LEN_W'(1));

  // RAM port decode from state; reset forces IDLE so mem_we drops asynchronously
  always_comb begin
    w_mem_a  = '0;
    w_mem_we = 1'b0;
    w_mem_wd = '0;
    case (r_state)
      S_RD: begin
        w_mem_a = r_src_ptr;
      end
      S_WR, S_FILL: begin
        w_mem_a  = r_dst_ptr;
        w_mem_we = 1'b1;
        w_mem_wd = r_mode ? r_fill : r_rd_buf;
      end
      default: begin
        w_mem_a  = '0;
        w_mem_we = 1'b0;
        w_mem_wd = '0;
      end
    endcase
  end

  // Transfer sequencer with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_src_ptr    <= '0;
      r_dst_ptr    <= '0;
      r_rem        <= '0;
      r_words_done <= '0;
      r_fill       <= '0;
      r_rd_buf     <= '0;
      r_mode       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_src_ptr    <= bus.src_addr & ALIGN_MASK;
            r_dst_ptr    <= bus.dst_addr & ALIGN_MASK;
            r_rem        <= bus.len;
            r_fill       <= bus.fill_data;
            r_mode       <= bus.mode;
            r_words_done <= '0;
            r_aborted    <= 1'b0;
            if (bus.len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= bus.mode ? S_FILL : S_RD;
              r_busy  <= 1'b1;
            end
          end
        end

        S_RD: begin
          if (bus.abort) begin
            // read is dropped; nothing was written this cycle
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else begin
            r_rd_buf <= bus.mem_rd;
            r_state  <= S_WR;
          end
        end

        S_WR: begin
          // write in this cycle commits even when abort is sampled
          r_src_ptr    <= r_src_ptr + WORD_STEP;
          r_dst_ptr    <= r_dst_ptr + WORD_STEP;
          r_words_done <= r_words_done + LEN_W'(1);
          r_rem        <= r_rem - LEN_W'(1);
          if (bus.abort) begin
            r_aborted <= 1'b1;
          end
          if (bus.abort || w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_RD;
          end
        end

        S_FILL: begin
          r_dst_ptr    <= r_dst_ptr + WORD_STEP;
          r_words_done <= r_words_done + LEN_W'(1);
          r_rem        <= r_rem - LEN_W'(1);
          if (bus.abort) begin
            r_aborted <= 1'b1;
          end
          if (bus.abort || w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.aborted    = r_aborted;
  assign bus.words_done = r_words_done;
  assign bus.mem_a      = w_mem_a;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_wd     = w_mem_wd;

endmodule

// File: tb/tb_mem_dma_engine.sv
// Directed plus randomized transfers against a word-array RAM model.
module tb_mem_dma_engine;

  logic clk;
  logic rst_n;

  mem_dma_if #(.LEN_W(8), .DATA_W(32)) bus ();

  mem_dma_engine #(.LEN_W(8), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 256-word RAM behind the port, plus a bench-side preload path
  logic [31:0] ram   [0:255];
  logic [31:0] m_ram [0:255];
  logic        tb_we;
  logic [7:0]  tb_idx;
  logic [31:0] tb_val;

  assign bus.mem_rd = ram[bus.mem_a[9:2]];

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_a[9:2]] <= bus.mem_wd;
    else if (tb_we) ram[tb_idx] <= tb_val;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    @(negedge clk);
    tb_we  = 1'b1;
    tb_idx = 8'(idx);
    tb_val = v;
    m_ram[idx] = v;
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("%s_ram[%0d]", tag, i), 64'(ram[i]), 64'(m_ram[i]));
    end
  endtask

  // One transfer: ab = abort cycle (0 = none), rs = cycle of a stray start pulse (0 = none)
  task automatic run_xfer(input string tag, input logic md, input logic [31:0] sa,
                          input logic [31:0] da, input int n, input logic [31:0] fd,
                          input int ab, input int rs);
    logic [31:0] s, d, a_src, a_dst;
    logic [34:0] obs, exp;
    int e0, e, w;
    logic exp_ab;
    s = sa & ~32'h3;
    d = da & ~32'h3;
    e0 = (n == 0) ? 1 : (md ? n + 1 : 2 * n + 1);
    exp_ab = (ab > 0) && (ab < e0);
    e = exp_ab ? ab + 1 : e0;
    w = exp_ab ? (md ? ab : ab / 2) : n;

    @(negedge clk);
    tb_we         = 1'b0;
    bus.start     = 1'b1;
    bus.mode      = md;
    bus.src_addr  = sa;
    bus.dst_addr  = da;
    bus.len       = 8'(n);
    bus.fill_data = fd;
    bus.abort     = 1'b0;

    for (int c = 1; c <= e; c++) begin
      @(negedge clk);
      bus.start = (c == rs) && (c < e);
      bus.abort = (c == ab);
      if (c == 1) begin
        bus.mode      = ~md;
        bus.src_addr  = $urandom;
        bus.dst_addr  = $urandom;
        bus.len       = 8'($urandom);
        bus.fill_data = $urandom;
      end
      if (c == e) exp = {1'b0, 1'b1, 1'b0, 32'h0};
      else if (md) exp = {1'b1, 1'b0, 1'b1, d + 32'(4 * (c - 1))};
      else if ((c % 2) == 1) exp = {1'b1, 1'b0, 1'b0, s + 32'(4 * ((c - 1) / 2))};
      else exp = {1'b1, 1'b0, 1'b1, d + 32'(4 * (c / 2 - 1))};
      obs = {bus.busy, bus.done, bus.mem_we, bus.mem_a};
      chk($sformatf("%s_cyc%0d{busy,done,we,a}", tag, c), 64'(obs), 64'(exp));
    end

    // Ascending word order: word i read before word i written
    for (int i = 0; i < w; i++) begin
      a_src = s + 32'(4 * i);
      a_dst = d + 32'(4 * i);
      m_ram[a_dst[9:2]] = md ? fd : m_ram[a_src[9:2]];
    end

    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk({tag, "_words_done"}, 64'(bus.words_done), 64'(w));
    chk({tag, "_aborted"}, 64'(bus.aborted), 64'(exp_ab));
    chk({tag, "_idle"}, 64'({bus.busy, bus.done, bus.mem_we}), 64'(0));
    check_ram(tag);
  endtask

  initial begin
    int n, ab, rs;
    logic md;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    tb_we = 1'b0;
    tb_idx = '0;
    tb_val = '0;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.src_addr = '0;
    bus.dst_addr = '0;
    bus.len = '0;
    bus.fill_data = '0;
    bus.abort = 1'b0;

    #3;
    chk("reset_status", 64'({bus.busy, bus.done, bus.aborted, bus.mem_we, bus.words_done}), 64'(0));
    chk("reset_mem_a", 64'(bus.mem_a), 64'(0));
    chk("reset_mem_wd", 64'(bus.mem_wd), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) set_word(i, $urandom);
    set_word(0, 32'h11);
    set_word(1, 32'h22);
    set_word(2, 32'h33);
    set_word(3, 32'h44);

    run_xfer("copy4", 1'b0, 32'h0, 32'h40, 4, 32'h0, 0, 0);
    run_xfer("fill3", 1'b1, 32'h0, 32'h10, 3, 32'hDEAD_BEEF, 0, 0);
    run_xfer("zero", 1'b0, 32'h0, 32'h60, 0, 32'h0, 0, 0);
    run_xfer("abort", 1'b0, 32'h0, 32'h80, 5, 32'h0, 4, 0);
    run_xfer("align", 1'b0, 32'h3, 32'h21, 2, 32'h0, 0, 2);
    run_xfer("wrap_copy", 1'b0, 32'hFFFF_FFFC, 32'h100, 2, 32'h0, 0, 0);
    run_xfer("wrap_fill", 1'b1, 32'h0, 32'hFFFF_FFF8, 3, 32'hCAFE_F00D, 0, 0);
    run_xfer("abort_rd", 1'b0, 32'h200, 32'h240, 4, 32'h0, 3, 0);
    run_xfer("abort_fill", 1'b1, 32'h0, 32'h2C0, 6, 32'h1234_5678, 2, 0);

    // Reset asserted during the first WR of a copy
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 1'b0;
    bus.src_addr = 32'h0;
    bus.dst_addr = 32'h200;
    bus.len = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_pre_we", 64'(bus.mem_we), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_we", 64'(bus.mem_we), 64'(0));
    chk("rst_async_status", 64'({bus.busy, bus.done, bus.aborted, bus.words_done}), 64'(0));
    chk("rst_async_mem_a", 64'(bus.mem_a), 64'(0));
    chk("rst_async_mem_wd", 64'(bus.mem_wd), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    check_ram("rst_nowrite");
    run_xfer("post_rst", 1'b0, 32'h10, 32'h300, 1, 32'h0, 0, 0);

    // Randomized transfers
    for (int t = 0; t < 14; t++) begin
      n  = $urandom_range(0, 10);
      md = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * n + 1) : 0;
      rs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * n + 1) : 0;
      run_xfer($sformatf("rnd%0d", t), md, $urandom, $urandom, n, $urandom, ab, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
